instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter: FIFO_DEPTH, 2, instruction buffer entries; only the value 2 is supported.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: imem_req  output  1  instruction memory read strobe.
REQ-006 Port: imem_addr  output  32  byte address of the read; bits [1:0] always 0.
REQ-007 Port: imem_rdata  input  32  read data, valid exactly one cycle after imem_req=1.
REQ-008 Port: redirect  input  1  branch-taken or jump from the control unit.
REQ-009 Port: redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-010 Port: out_valid  output  1  instr and instr_pc hold a fetched instruction.
REQ-011 Port: out_ready  input  1  control unit accepts the instruction this cycle.
REQ-012 Port: instr  output  32  instruction word at the FIFO head, fed to the control unit instr input.
REQ-013 Port: instr_pc  output  32  byte address of instr.

Function
REQ-014 The FSM SHALL have three states: IDLE, FETCH and BLOCKED.
REQ-015 IDLE is held while rst=1; the first cycle with rst=0 SHALL be FETCH.
REQ-016 imem_req SHALL be 1 in FETCH when redirect=0 and (count + inflight - pop) < 2; otherwise the unit is BLOCKED and imem_req SHALL be 0.
REQ-017 In the above, pop = out_valid & out_ready, and inflight = registered imem_req.
REQ-018 Each issued request SHALL use imem_addr=pc, then advance pc by 4 modulo 2^32 (FFFF_FFFC wraps to 0000_0000).
REQ-019 The response SHALL be written into the FIFO together with its address in the cycle it arrives; out_valid SHALL rise on the following cycle.
REQ-020 Request-to-out_valid latency SHALL be 2 cycles.
REQ-021 With out_ready held at 1, the unit SHALL sustain one instruction per cycle.
REQ-022 out_valid=1 with out_ready=0 SHALL hold instr and instr_pc stable, and no FIFO entry SHALL be lost or duplicated.
REQ-023 A redirect cycle SHALL: complete any handshake in that same cycle; then clear the FIFO; discard the response arriving in that cycle; drive imem_req=0; and load pc={redirect_pc[31:2],2'b00}.
REQ-024 The first request after a redirect SHALL issue on the next cycle at the new pc.
REQ-025 out_valid SHALL be 0 in the cycle after a redirect.
REQ-026 Successive redirects on consecutive cycles SHALL take the last one.
REQ-027 Simultaneous FIFO write and pop SHALL keep count unchanged.
REQ-028 A write into a full FIFO cannot occur by construction (REQ-016); assertion-checked in simulation.

Reset
REQ-029 While rst=1, outputs SHALL be: imem_req=0, imem_addr=RESET_PC, out_valid=0, instr=0, instr_pc=0.
REQ-030 While rst=1: pc=RESET_PC, FIFO empty, inflight=0, state IDLE.
REQ-031 rst asserted mid-operation SHALL discard FIFO contents and any in-flight response in the same cycle.

Configuration
REQ-032 With macro FETCH_STALL_CNT_EN defined, the block SHALL add output port stall_cnt (16 bits).
REQ-033 stall_cnt SHALL increment each cycle with out_valid=1 & out_ready=0, saturate at FFFF, and clear on rst.
REQ-034 Without FETCH_STALL_CNT_EN, the port and its logic SHALL be absent.

Verification
REQ-035 Reset release with RESET_PC=0 and out_ready=1 -> imem_addr 0,4,8 on cycles 0,1,2; out_valid on cycle 2 with instr_pc=0.
REQ-036 out_ready=0 for 5 cycles after the first out_valid -> imem_req stops with 2 entries held; instr_pc stays 0; release yields pcs 0,4,8 with no gap or duplicate.
REQ-037 Redirect to 0x0000_0041 while a request to 0x10 is in flight -> the 0x10 response is dropped; next imem_addr=0x40; next out_valid has instr_pc=0x40.
REQ-038 The controller's add/addi/bne/j words preloaded at 0x0..0xC -> instr presents them in order, each held until out_ready.
REQ-039 pc=0xFFFF_FFFC fetch -> the next imem_addr is 0x0000_0000.
REQ-040 With FETCH_STALL_CNT_EN, out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF; after rst, stall_cnt=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: sequential imem reads into a 2-entry instruction buffer; FETCH_STALL_CNT_EN adds stall_cnt.
// Latency: 2 cycles from imem_req to out_valid; one instruction per cycle while out_ready stays high.
// Backpressure: out_ready low holds the head; requests stop once buffered plus in-flight entries reach FIFO_DEPTH.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, BLOCKED} state_t;

    localparam logic [2:0]  DEPTH       = 3'(FIFO_DEPTH);
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    state_t      state, state_q;
    logic [31:0] pc;
    logic [31:0] resp_pc;
    logic        inflight;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        pop, wr_en, space;
    logic [2:0]  occ;
    logic        unused_bits;

    assign unused_bits = &{1'b0, redirect_pc[1:0]};

    assign out_valid = !rst && (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // A response landing in a redirect or reset cycle belongs to the abandoned stream.
    assign wr_en     = inflight && !redirect && !rst;
    assign occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign space     = occ < DEPTH;

    assign imem_addr = rst ? RESET_PC_AL : pc;
    assign instr     = rst ? 32'd0 : fifo_instr[rd_ptr];
    assign instr_pc  = rst ? 32'd0 : fifo_pc[rd_ptr];

    always_comb begin
        state = BLOCKED;
        if (rst) begin
            state = IDLE;
        end else if (!redirect && (state_q == IDLE || space)) begin
            state = FETCH;
        end
        imem_req = (state == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc       <= RESET_PC_AL;
            resp_pc  <= RESET_PC_AL;
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            state_q  <= state;
            inflight <= imem_req;
            if (imem_req) begin
                resp_pc <= pc;
            end
            if (redirect) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (imem_req) begin
                pc <= pc + 32'd4;
            end
            if (redirect) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= !wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= !rd_ptr;
                end
                case ({wr_en, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr_en && !pop && count == 2'd2));
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle checks plus a queue of expected (pc, instr) pairs.
// A monitor pops the queue on every out_valid/out_ready handshake and checks head stability while stalled.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q [$];
    logic        hold_pend = 1'b0;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        req_s;
    logic [31:0] addr_s;
    logic        drained;
    logic [15:0] pat;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: add, addi, bne, j at 0x0..0xC, address-tagged filler elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h002081B3;
            32'h4:   return 32'h00500093;
            32'h8:   return 32'hFE209CE3;
            32'hC:   return 32'hFF5FF06F;
            default: return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    always @(posedge clk) begin
        req_s  = imem_req;
        addr_s = imem_addr;
        #1;
        imem_rdata = req_s ? mem_word(addr_s) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        rst         = r;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #2;
    endtask

    task automatic push_range(input logic [31:0] start, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            exp_q.push_back({a, mem_word(a)});
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_addr",  imem_addr,      RESET_PC);
        chk("rst_vld",   32'(out_valid), 32'd0);
        chk("rst_instr", instr,          32'd0);
        chk("rst_pc",    instr_pc,       32'd0);
        chk("leftover",  32'(exp_q.size()), 32'd0);
        exp_q.delete();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst2_vld",  32'(out_valid), 32'd0);
        chk("rst2_req",  32'(imem_req),  32'd0);
    endtask

    // Monitor: handshake scoreboard and stall stability.
    always @(negedge clk) begin
        #2;
        if (hold_pend && !rst) begin
            chk("hold_vld",   32'(out_valid), 32'd1);
            chk("hold_pc",    instr_pc,       hold_pc);
            chk("hold_instr", instr,          hold_instr);
        end
        hold_pend  = !rst && out_valid && !out_ready && !redirect;
        hold_pc    = instr_pc;
        hold_instr = instr;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got pc %h expected no output", instr_pc);
            end else begin
                chk("out_pc",    instr_pc, exp_q[0][63:32]);
                chk("out_instr", instr,    exp_q[0][31:0]);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got %0d tests expected completion", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset release with out_ready high: addresses 0,4,8, first output on cycle 2.
        do_reset();
        push_range(32'h0, 8);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s1_c0_req", 32'(imem_req), 32'd1);
        chk("s1_c0_addr", imem_addr, 32'h0);
        chk("s1_c0_vld", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s1_c1_addr", imem_addr, 32'h4);
        chk("s1_c1_vld", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s1_c2_addr", imem_addr, 32'h8);
        chk("s1_c2_vld", 32'(out_valid), 32'd1);
        chk("s1_c2_pc", instr_pc, 32'h0);
        chk("s1_c2_instr", instr, 32'h002081B3);
        repeat (7) cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Stall for 5 cycles after the first out_valid, then release.
        do_reset();
        push_range(32'h0, 5);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        for (int c = 2; c <= 6; c++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            chk("s2_stall_req", 32'(imem_req), 32'd0);
            chk("s2_stall_pc", instr_pc, 32'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s2_c7_req", 32'(imem_req), 32'd1);
        chk("s2_c7_addr", imem_addr, 32'h8);
        for (int c = 8; c <= 11; c++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            chk("s2_novgap", 32'(out_valid), 32'd1);
        end

        // Redirect to 0x41 while the 0x10 request is in flight.
        do_reset();
        push_range(32'h0, 4);
        push_range(32'h40, 3);
        for (int c = 0; c <= 4; c++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s3_c4_addr", imem_addr, 32'h10);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0041);
        chk("s3_rd_req", 32'(imem_req), 32'd0);
        chk("s3_rd_pc", instr_pc, 32'hC);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s3_after_vld", 32'(out_valid), 32'd0);
        chk("s3_after_req", 32'(imem_req), 32'd1);
        chk("s3_after_addr", imem_addr, 32'h40);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s3_c7_vld", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s3_c8_vld", 32'(out_valid), 32'd1);
        chk("s3_c8_pc", instr_pc, 32'h40);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Back-to-back redirects (last wins) and address wrap at 0xFFFF_FFFC.
        do_reset();
        push_range(32'hFFFF_FFFC, 3);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        chk("s4_rd1_req", 32'(imem_req), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        chk("s4_rd2_req", 32'(imem_req), 32'd0);
        chk("s4_rd2_vld", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s4_c3_vld", 32'(out_valid), 32'd0);
        chk("s4_c3_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s4_wrap_addr", imem_addr, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("s4_c5_pc", instr_pc, 32'hFFFF_FFFC);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Irregular out_ready pattern, then drain with out_ready high.
        do_reset();
        push_range(32'h0, 20);
        pat = 16'b0110_1001_1100_1010;
        for (int i = 0; i < 16; i++) cyc(1'b0, pat[i], 1'b0, 32'h0);
        drained = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            #1;
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("s5_drain", 32'(drained), 32'd1);
        do_reset();

`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt_init", 32'(stall_cnt), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (70000) @(negedge clk);
        #2;
        chk("stall_cnt_sat", 32'(stall_cnt), 32'h0000_FFFF);
        do_reset();
        chk("stall_cnt_clr", 32'(stall_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
